// File: rtl/avalon_arb_pkg.sv
// Shared definitions for the Avalon register-port arbiter: master index type
// and the round-robin selection function.
package avalon_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = $clog2(MAX_MASTERS);

  typedef logic [IDX_W-1:0] idx_t;

  // Returns the first requester found searching last+1, last+2, ... modulo n.
  // The result is only meaningful when at least one of req[n-1:0] is set.
  function automatic idx_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                   input idx_t last,
                                   input int n);
    idx_t pick;
    idx_t cand;
    pick = last;
    for (int k = MAX_MASTERS; k >= 1; k--) begin
      if (k <= n) begin
        cand = idx_t'((int'(last) + k) % n);
        if (req[cand]) pick = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/avalon_rr_picker.sv
// Combinational round-robin picker: rotates the request vector past the last
// grant, priority-encodes, and maps the hit back to a master index.
module avalon_rr_picker
  import avalon_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  idx_t         last,
  output logic         vld,
  output idx_t         idx
);

  logic [MAX_MASTERS-1:0] req_pad;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    vld            = |req;
    idx            = rr_pick(req_pad, last, N);
  end

endmodule

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one avalon_core register port between
// NUM_MASTERS requesters, with lock support and 1-cycle read-return routing.
module avalon_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
  output logic [NUM_MASTERS-1:0]            m_wait,
  output logic [NUM_MASTERS-1:0]            m_read_valid,
  output logic [DATA_WIDTH-1:0]             m_data_out,
  output logic                              m_irq,
  output logic                              s_read,
  output logic                              s_write,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_data_in,
  input  logic                              s_read_valid,
  input  logic [DATA_WIDTH-1:0]             s_data_out,
  input  logic                              s_irq
);

  logic [NUM_MASTERS-1:0] req, owner_oh, elig, grant;
  logic                   lock_hold, pick_vld, gnt_vld, lock_req;
  idx_t                   pick_idx;

  idx_t last_grant_q, last_grant_d;
  idx_t lock_owner_q, lock_owner_d;
  idx_t rd_owner_q,   rd_owner_d;
  logic locked_q,     locked_d;
  logic rd_pending_q, rd_pending_d;

  // The lock only holds while its owner keeps m_lock high; the release cycle
  // already arbitrates among everyone.
  always_comb begin
    req = m_read | m_write;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner_oh[i] = (lock_owner_q == idx_t'(i));
    end
    lock_hold = locked_q & |(m_lock & owner_oh);
    elig      = lock_hold ? (req & owner_oh) : req;
  end

  avalon_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req  (elig),
    .last (last_grant_q),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  always_comb begin
    gnt_vld      = pick_vld & ~reset;
    grant        = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_address    = '0;
    s_data_in    = '0;
    lock_req     = 1'b0;
    m_read_valid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant[i]        = gnt_vld & (pick_idx == idx_t'(i));
      s_read          = s_read  | (grant[i] & m_read[i] & ~m_write[i]);
      s_write         = s_write | (grant[i] & m_write[i]);
      s_address       = s_address | ({ADDR_WIDTH{grant[i]}} & m_address[i*ADDR_WIDTH +: ADDR_WIDTH]);
      s_data_in       = s_data_in | ({DATA_WIDTH{grant[i]}} & m_data_in[i*DATA_WIDTH +: DATA_WIDTH]);
      lock_req        = lock_req | (grant[i] & m_lock[i]);
      m_read_valid[i] = s_read_valid & rd_pending_q & (rd_owner_q == idx_t'(i));
    end
    m_wait = req & ~grant;
  end

  assign m_data_out = s_data_out;
  assign m_irq      = s_irq;

  always_comb begin
    last_grant_d = gnt_vld ? pick_idx : last_grant_q;
    lock_owner_d = lock_owner_q;
    locked_d     = locked_q;
    if (lock_req) begin
      locked_d     = 1'b1;
      lock_owner_d = pick_idx;
    end else if (locked_q && !lock_hold) begin
      locked_d = 1'b0;
    end
    rd_pending_d = s_read;
    rd_owner_d   = s_read ? pick_idx : rd_owner_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= idx_t'(NUM_MASTERS - 1);
      locked_q     <= 1'b0;
      lock_owner_q <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Bench for avalon_arbiter: small register-core model behind the slave port,
// expected read returns queued when a read is driven and popped a cycle later.
module tb_avalon_arbiter;

  localparam int NM = 2;
  localparam int AW = 2;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [NM-1:0]      m_read, m_write, m_lock;
  logic [NM*AW-1:0]   m_address;
  logic [NM*DW-1:0]   m_data_in;
  logic [NM-1:0]      m_wait, m_read_valid;
  logic [DW-1:0]      m_data_out;
  logic               m_irq;
  logic               s_read, s_write;
  logic [AW-1:0]      s_address;
  logic [DW-1:0]      s_data_in;
  logic               s_read_valid;
  logic [DW-1:0]      s_data_out;
  logic               s_irq;

  logic [DW-1:0] core_mem  [4];
  logic [DW-1:0] model_mem [4];

  typedef struct {
    logic [NM-1:0] vld;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_lock       (m_lock),
    .m_address    (m_address),
    .m_data_in    (m_data_in),
    .m_wait       (m_wait),
    .m_read_valid (m_read_valid),
    .m_data_out   (m_data_out),
    .m_irq        (m_irq),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_address    (s_address),
    .s_data_in    (s_data_in),
    .s_read_valid (s_read_valid),
    .s_data_out   (s_data_out),
    .s_irq        (s_irq)
  );

  // Register core with a fixed 1-cycle read latency; it ignores reset for
  // its response path so a stale response can appear after a reset.
  always @(posedge clk) begin
    s_read_valid <= s_read;
    if (s_read) s_data_out <= core_mem[s_address];
    if (reset) begin
      for (int i = 0; i < 4; i++) core_mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (s_write) begin
      core_mem[s_address] <= s_data_in;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset(input logic [NM-1:0] rd);
    rsp_t e;
    reset     = 1'b1;
    m_read    = rd;
    m_write   = '0;
    m_lock    = '0;
    m_address = '0;
    m_data_in = '0;
    #3;
    check("rst_m_wait", m_wait, rd);
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_read_valid", m_read_valid, 0);
    sb_q.delete();
    e.vld  = '0;
    e.data = '0;
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) model_mem[i] = 32'hA000_0000 | 32'(i);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One bus cycle: drive, check combinational grant against the expected
  // winner (-1 = none), retire one queued response, queue the next one.
  task automatic cycle(input logic [NM-1:0] rd, input logic [NM-1:0] wr,
                       input logic [NM-1:0] lk, input logic [NM*AW-1:0] addr,
                       input logic [NM*DW-1:0] din, input int win);
    logic [NM-1:0] req, gv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          er, ew;
    rsp_t          e;
    m_read    = rd;
    m_write   = wr;
    m_lock    = lk;
    m_address = addr;
    m_data_in = din;
    #3;
    req = rd | wr;
    gv  = '0;
    er  = 1'b0;
    ew  = 1'b0;
    wa  = '0;
    wd  = '0;
    if (win >= 0) begin
      gv[win] = 1'b1;
      wa      = addr[win*AW +: AW];
      wd      = din[win*DW +: DW];
      ew      = wr[win];
      er      = rd[win] & ~wr[win];
    end
    check("m_wait", m_wait, req & ~gv);
    check("s_read", s_read, er);
    check("s_write", s_write, ew);
    if (win >= 0) begin
      check("s_address", s_address, wa);
      if (ew) check("s_data_in", s_data_in, wd);
    end
    if (sb_q.size() == 0) begin
      check("sb_entry_present", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("m_read_valid", m_read_valid, e.vld);
      if (e.vld != '0) check("m_data_out", m_data_out, e.data);
    end
    e.vld  = '0;
    e.data = '0;
    if (er) begin
      e.vld  = gv;
      e.data = model_mem[wa];
    end
    sb_q.push_back(e);
    if (ew) model_mem[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_irq = 1'b0;
    do_reset(2'b11);

    // Both read address 0: master 0 first, then master 1.
    cycle(2'b11, 2'b00, 2'b00, {2'd0, 2'd0}, '0, 0);
    cycle(2'b11, 2'b00, 2'b00, {2'd0, 2'd0}, '0, 1);
    cycle(2'b00, 2'b00, 2'b00, '0, '0, -1);

    // Continuous writes from both alternate.
    for (int k = 0; k < 6; k++)
      cycle(2'b00, 2'b11, 2'b00, {2'd3, 2'd2},
            {32'h1100 | 32'(k), 32'h2200 | 32'(k)}, k % 2);

    // Lock: master 1 read + write under lock while master 0 waits.
    cycle(2'b00, 2'b01, 2'b00, {2'd0, 2'd0}, {32'h0, 32'hC0}, 0);
    cycle(2'b11, 2'b00, 2'b10, {2'd1, 2'd3}, '0, 1);
    cycle(2'b01, 2'b10, 2'b10, {2'd1, 2'd3}, {32'h5, 32'h0}, 1);
    cycle(2'b01, 2'b00, 2'b00, {2'd1, 2'd3}, '0, 0);

    // Lock held by an idle owner stalls the other master.
    cycle(2'b00, 2'b10, 2'b10, {2'd0, 2'd0}, {32'h77, 32'h0}, 1);
    cycle(2'b00, 2'b01, 2'b10, {2'd0, 2'd1}, {32'h0, 32'h99}, -1);
    cycle(2'b00, 2'b01, 2'b00, {2'd0, 2'd1}, {32'h0, 32'h99}, 0);

    // Read and write together counts as a write only.
    cycle(2'b01, 2'b01, 2'b00, {2'd0, 2'd2}, {32'h0, 32'hDEAD}, 0);

    // Streaming reads from a single master.
    for (int k = 0; k < 4; k++)
      cycle(2'b01, 2'b00, 2'b00, {2'd0, 2'd2}, '0, 0);
    cycle(2'b00, 2'b00, 2'b00, '0, '0, -1);

    // Reset right after an accepted read drops its response.
    cycle(2'b01, 2'b00, 2'b00, {2'd0, 2'd1}, '0, 0);
    do_reset(2'b00);
    cycle(2'b11, 2'b00, 2'b00, {2'd0, 2'd0}, '0, 0);
    cycle(2'b00, 2'b00, 2'b00, '0, '0, -1);

    // Interrupt passthrough with an idle bus.
    s_irq = 1'b1;
    #1;
    check("m_irq_high", m_irq, 1);
    cycle(2'b00, 2'b00, 2'b00, '0, '0, -1);
    s_irq = 1'b0;
    #1;
    check("m_irq_low", m_irq, 0);
    cycle(2'b00, 2'b00, 2'b00, '0, '0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
